mdu_seq: RTL

Multi-cycle 32-bit multiply/divide unit for the MIPS datapath, executing MULT, MULTU, DIV and DIVU. It sits directly upstream of the HI and LO 32-bit load registers. It produces the 64-bit result on `hi`/`lo` and a one-cycle `done` pulse that drives their load enables. Arithmetic is iterative: one shift-add or restore step per clock, behind a start/busy/done handshake with the control unit.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_cneg.sv | 17 +
 rtl/mdu_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings for the sequential multiply/divide unit
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam int ITER = 32;

endpackage

// File: rtl/mdu_cneg.sv
// rtl/mdu_cneg.sv - conditional two's-complement negate
module mdu_cneg #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    always_comb begin
        y = a;
        if (neg) begin
            y = ~a + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative 32-bit MULT/MULTU/DIV/DIVU feeding the HI/LO registers
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] T,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    import mdu_pkg::*;

    localparam int CW = $clog2(ITER);

    state_e               state, state_nx;
    op_e                  op_r;
    logic [WIDTH-1:0]     s_r, t_r;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 sgn_s, sgn_t;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;

    logic                 is_signed, is_div;
    logic                 neg_lo_en, neg_hi_en;
    logic [WIDTH-1:0]     neg_lo_in, neg_hi_in, neg_lo_out, neg_hi_out;
    logic [2*WIDTH-1:0]   prod_out;
    logic [2*WIDTH-1:0]   mul_next, div_next;
    logic [WIDTH:0]       rem_sh, rem_diff;
    logic [WIDTH-1:0]     rem_new;
    logic                 q_bit;

    assign is_signed = (op_r == OP_MULT) || (op_r == OP_DIV);
    assign is_div    = (op_r == OP_DIVU) || (op_r == OP_DIV);

    // The two 32-bit negators are shared: operand magnitudes in PREP, quotient/remainder fix in FIX.
    always_comb begin
        if (state == ST_PREP) begin
            neg_lo_en = is_signed & s_r[WIDTH-1];
            neg_lo_in = s_r;
            neg_hi_en = is_signed & t_r[WIDTH-1];
            neg_hi_in = t_r;
        end else begin
            neg_lo_en = sgn_s ^ sgn_t;
            neg_lo_in = acc[WIDTH-1:0];
            neg_hi_en = sgn_s;
            neg_hi_in = acc[2*WIDTH-1:WIDTH];
        end
    end

    mdu_cneg #(.W(WIDTH)) u_neg_lo (.neg(neg_lo_en), .a(neg_lo_in), .y(neg_lo_out));
    mdu_cneg #(.W(WIDTH)) u_neg_hi (.neg(neg_hi_en), .a(neg_hi_in), .y(neg_hi_out));
    mdu_cneg #(.W(2*WIDTH)) u_neg_prod (.neg(sgn_s ^ sgn_t), .a(acc), .y(prod_out));

    // MSB-first iteration: the counter doubles as the bit index into the multiplier/dividend.
    always_comb begin
        mul_next = {acc[2*WIDTH-2:0], 1'b0} +
                   (b_mag[cnt] ? {{WIDTH{1'b0}}, a_mag} : {(2*WIDTH){1'b0}});
        rem_sh   = {acc[2*WIDTH-1:WIDTH], a_mag[cnt]};
        rem_diff = rem_sh - {1'b0, b_mag};
        q_bit    = ~rem_diff[WIDTH];
        rem_new  = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        div_next = {rem_new, acc[WIDTH-2:0], q_bit};
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_PREP;
            ST_PREP: state_nx = ST_RUN;
            ST_RUN:  if (cnt == '0) state_nx = ST_FIX;
            ST_FIX:  state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            op_r     <= OP_MULTU;
            s_r      <= '0;
            t_r      <= '0;
            a_mag    <= '0;
            b_mag    <= '0;
            sgn_s    <= 1'b0;
            sgn_t    <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_r <= op_e'(op);
                        s_r  <= S;
                        t_r  <= T;
                    end
                end
                ST_PREP: begin
                    a_mag <= neg_lo_out;
                    b_mag <= neg_hi_out;
                    sgn_s <= neg_lo_en;
                    sgn_t <= neg_hi_en;
                    cnt   <= CW'(ITER - 1);
                    acc   <= '0;
                end
                ST_RUN: begin
                    acc <= is_div ? div_next : mul_next;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_FIX: begin
                    if (!is_div) begin
                        {hi, lo} <= prod_out;
                        div_zero <= 1'b0;
                    end else if (t_r == '0) begin
                        lo       <= '1;
                        hi       <= s_r;
                        div_zero <= 1'b1;
                    end else begin
                        lo       <= neg_lo_out;
                        hi       <= neg_hi_out;
                        div_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
